// File: rtl/comp_mul_pkg.sv
// Shared sizing helpers and the default-width complex type for the comp_mul_pipe slice.
// Latency: none (types and constants only).
// Backpressure: n/a. Macro COMP_MUL_ACC_EN widens the result by the accumulator guard bits.
package comp_mul_pkg;

    localparam int COMP_MUL_DATA_W    = 8;
    localparam int COMP_MUL_ACC_GUARD = 4;

`ifdef COMP_MUL_ACC_EN
    localparam bit COMP_MUL_ACC = 1'b1;
`else
    localparam bit COMP_MUL_ACC = 1'b0;
`endif

    // Width of one partial product of two signed dw-bit components.
    function automatic int prod_w(input int dw);
        return 2 * dw;
    endfunction

    // Result width: exact sum of two products, plus guard bits when accumulating.
    function automatic int out_w(input int dw, input int guard);
        return 2 * dw + 1 + (COMP_MUL_ACC ? guard : 0);
    endfunction

    // Complex sample at the default component width.
    typedef struct packed {
        logic signed [COMP_MUL_DATA_W-1:0] re;
        logic signed [COMP_MUL_DATA_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/comp_mul_prod.sv
// S2 bank of the four signed partial products ar*br, ai*bi, ai*br, ar*bi.
// Latency: 1 cycle (registered on en_i).
// Backpressure: none internally; the bank holds its contents whenever en_i is low.
module comp_mul_prod
    import comp_mul_pkg::*;
#(
    parameter int DATA_W = COMP_MUL_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_i,
    input  logic signed [DATA_W-1:0]   ar_i,
    input  logic signed [DATA_W-1:0]   ai_i,
    input  logic signed [DATA_W-1:0]   br_i,
    input  logic signed [DATA_W-1:0]   bi_i,
    output logic signed [2*DATA_W-1:0] p_rr_o,
    output logic signed [2*DATA_W-1:0] p_ii_o,
    output logic signed [2*DATA_W-1:0] p_ir_o,
    output logic signed [2*DATA_W-1:0] p_ri_o
);
    localparam int PW = prod_w(DATA_W);

    logic signed [PW-1:0] p_rr_d, p_ii_d, p_ir_d, p_ri_d;
    logic signed [PW-1:0] p_rr_q, p_ii_q, p_ir_q, p_ri_q;

    // Operands are widened first so each product is formed at its exact width.
    always_comb begin
        p_rr_d = PW'(ar_i) * PW'(br_i);
        p_ii_d = PW'(ai_i) * PW'(bi_i);
        p_ir_d = PW'(ai_i) * PW'(br_i);
        p_ri_d = PW'(ar_i) * PW'(bi_i);
    end

    // Product registers load only when the stage advances with a valid sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ir_q <= '0;
            p_ri_q <= '0;
        end else if (en_i) begin
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ir_q <= p_ir_d;
            p_ri_q <= p_ri_d;
        end
    end

    assign p_rr_o = p_rr_q;
    assign p_ii_o = p_ii_q;
    assign p_ir_o = p_ir_q;
    assign p_ri_o = p_ri_q;

endmodule

// File: rtl/comp_mul_pipe.sv
// Pipelined signed complex multiplier a*b or a*conj(b); optional complex MAC under COMP_MUL_ACC_EN.
// Latency: 3 cycles acceptance-to-o_vld, 1 sample/cycle.
// Backpressure: o_vld && !o_rdy freezes all stages; i_rdy is the combinational inverse of that stall.
module comp_mul_pipe
    import comp_mul_pkg::*;
#(
    parameter  int DATA_W    = COMP_MUL_DATA_W,
    parameter  int ACC_GUARD = COMP_MUL_ACC_GUARD,
    localparam int OUT_W     = out_w(DATA_W, ACC_GUARD)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] a_r,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_r,
    input  logic signed [DATA_W-1:0] b_i,
    input  logic                     i_conj,
    input  logic                     i_last,
    input  logic                     i_en,
    output logic                     i_rdy,
    output logic signed [OUT_W-1:0]  o_r,
    output logic signed [OUT_W-1:0]  o_i,
    output logic                     o_vld,
    input  logic                     o_rdy
);
    localparam int PW = prod_w(DATA_W);
    localparam int SW = PW + 1;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } op_t;

    logic                 stall, adv;
    op_t                  s1_a_q, s1_b_q;
    logic                 s1_vld_q, s1_conj_q;
    logic                 s2_vld_q, s2_conj_q;
    logic                 s3_vld_q;
    logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
    logic signed [SW-1:0] sum_r_d, sum_i_d;
    logic signed [OUT_W-1:0] o_r_q, o_i_q;

    assign stall = s3_vld_q && !o_rdy;
    assign adv   = !stall;
    assign i_rdy = adv;
    assign o_vld = s3_vld_q;
    assign o_r   = o_r_q;
    assign o_i   = o_i_q;

    // S1: capture operands and conjugate flag of each accepted sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_conj_q <= 1'b0;
        end else if (adv) begin
            s1_vld_q <= i_en;
            if (i_en) begin
                s1_a_q    <= '{re: a_r, im: a_i};
                s1_b_q    <= '{re: b_r, im: b_i};
                s1_conj_q <= i_conj;
            end
        end
    end

    comp_mul_prod #(.DATA_W(DATA_W)) u_prod (
        .clk    (clk),
        .rst    (rst),
        .en_i   (adv && s1_vld_q),
        .ar_i   (s1_a_q.re),
        .ai_i   (s1_a_q.im),
        .br_i   (s1_b_q.re),
        .bi_i   (s1_b_q.im),
        .p_rr_o (p_rr),
        .p_ii_o (p_ii),
        .p_ir_o (p_ir),
        .p_ri_o (p_ri)
    );

    // S2: valid bit and conjugate flag travel alongside the product bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_vld_q  <= 1'b0;
            s2_conj_q <= 1'b0;
        end else if (adv) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_conj_q <= s1_conj_q;
            end
        end
    end

    // S3 sums at 2*DATA_W+1 bits, which holds every product combination exactly.
    always_comb begin
        sum_r_d = SW'(p_rr) - SW'(p_ii);
        sum_i_d = SW'(p_ri) + SW'(p_ir);
        if (s2_conj_q) begin
            sum_r_d = SW'(p_rr) + SW'(p_ii);
            sum_i_d = SW'(p_ir) - SW'(p_ri);
        end
    end

`ifdef COMP_MUL_ACC_EN
    logic                    s1_last_q, s2_last_q;
    logic signed [OUT_W-1:0] acc_r_q, acc_i_q;
    logic signed [OUT_W-1:0] acc_r_d, acc_i_d;

    // Run-end flag rides through S1/S2 with its sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_last_q <= 1'b0;
            s2_last_q <= 1'b0;
        end else if (adv) begin
            if (i_en) begin
                s1_last_q <= i_last;
            end
            if (s1_vld_q) begin
                s2_last_q <= s1_last_q;
            end
        end
    end

    // Running total including the sample now leaving S2; wraps on overflow.
    always_comb begin
        acc_r_d = acc_r_q + OUT_W'(sum_r_d);
        acc_i_d = acc_i_q + OUT_W'(sum_i_d);
    end

    // Accumulate every sample; publish and restart from zero on the run's last sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_vld_q <= 1'b0;
            acc_r_q  <= '0;
            acc_i_q  <= '0;
            o_r_q    <= '0;
            o_i_q    <= '0;
        end else if (adv) begin
            s3_vld_q <= s2_vld_q && s2_last_q;
            if (s2_vld_q) begin
                acc_r_q <= s2_last_q ? '0 : acc_r_d;
                acc_i_q <= s2_last_q ? '0 : acc_i_d;
                if (s2_last_q) begin
                    o_r_q <= acc_r_d;
                    o_i_q <= acc_i_d;
                end
            end
        end
    end
`else
    logic unused_last;
    assign unused_last = i_last;

    // Every valid sample leaving S2 becomes one output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s3_vld_q <= 1'b0;
            o_r_q    <= '0;
            o_i_q    <= '0;
        end else if (adv) begin
            s3_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                o_r_q <= sum_r_d;
                o_i_q <= sum_i_d;
            end
        end
    end
`endif

endmodule

// File: tb/tb_comp_mul_pipe.sv
module tb_comp_mul_pipe;
    import comp_mul_pkg::*;

    localparam int DW = COMP_MUL_DATA_W;
    localparam int OW = out_w(DW, COMP_MUL_ACC_GUARD);

    typedef struct packed {
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
    } res_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] a_r = '0, a_i = '0, b_r = '0, b_i = '0;
    logic                 i_conj = 1'b0, i_last = 1'b0, i_en = 1'b0, o_rdy = 1'b1;
    logic                 i_rdy, o_vld;
    logic signed [OW-1:0] o_r, o_i;

    res_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
`ifdef COMP_MUL_ACC_EN
    longint mdl_acc_r = 0;
    longint mdl_acc_i = 0;
`endif

    comp_mul_pipe dut (
        .clk(clk), .rst(rst),
        .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
        .i_conj(i_conj), .i_last(i_last), .i_en(i_en), .i_rdy(i_rdy),
        .o_r(o_r), .o_i(o_i), .o_vld(o_vld), .o_rdy(o_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic cplx_t mk(input int r, input int i);
        cplx_t c;
        c.re = DW'(r);
        c.im = DW'(i);
        return c;
    endfunction

    function automatic cplx_t rnd();
        cplx_t c;
        c.re = DW'($urandom);
        c.im = DW'($urandom);
        return c;
    endfunction

    // Reference model: exact complex product, accumulated per run when the MAC is enabled.
    task automatic model_push(input cplx_t a, input cplx_t b, input bit conj, input bit last);
        longint ar, ai, br, bi, pr, pi;
        res_t   e;
        ar = a.re; ai = a.im; br = b.re; bi = b.im;
        pr = conj ? (ar * br + ai * bi) : (ar * br - ai * bi);
        pi = conj ? (ai * br - ar * bi) : (ar * bi + ai * br);
`ifdef COMP_MUL_ACC_EN
        mdl_acc_r += pr;
        mdl_acc_i += pi;
        if (last) begin
            e.re = OW'(mdl_acc_r);
            e.im = OW'(mdl_acc_i);
            sb.push_back(e);
            mdl_acc_r = 0;
            mdl_acc_i = 0;
        end
`else
        if (last || !last) begin
            e.re = OW'(pr);
            e.im = OW'(pi);
            sb.push_back(e);
        end
`endif
    endtask

    // One clock: drive after the falling edge, then report handshakes that the next rising edge completes.
    task automatic step(input bit en, input cplx_t a, input cplx_t b, input bit conj, input bit last,
                        input bit rdy, output bit took, output bit gave);
        @(negedge clk);
        i_en = en; a_r = a.re; a_i = a.im; b_r = b.re; b_i = b.im;
        i_conj = conj; i_last = last; o_rdy = rdy;
        #1;
        took = i_en && i_rdy;
        gave = o_vld && o_rdy;
        if (took) model_push(a, b, conj, last);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk); #1;
        n_cmp++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld: got %0b want 0", o_vld); end
        n_cmp++; if (o_r !== '0) begin n_bad++; $display("FAIL reset_o_r: got %0d want 0", o_r); end
        n_cmp++; if (o_i !== '0) begin n_bad++; $display("FAIL reset_o_i: got %0d want 0", o_i); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (i_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %0b want 1", i_rdy); end
    endtask

    task automatic test_mul();
        int ar[3] = '{10, 10, -128};
        int ai[3] = '{2, 2, -128};
        int br[3] = '{5, 5, -128};
        int bi[3] = '{1, 1, -128};
        bit cj[3] = '{1'b0, 1'b1, 1'b0};
        int er[3] = '{48, 52, 0};
        int ei[3] = '{20, 0, 32768};
        bit took, gave;
        int lat;
        res_t e;
        for (int v = 0; v < 3; v++) begin
            step(1'b1, mk(ar[v], ai[v]), mk(br[v], bi[v]), cj[v], 1'b1, 1'b1, took, gave);
            n_cmp++; if (!took) begin n_bad++; $display("FAIL mul_accept[%0d]: took %0b want 1", v, took); end
            lat = 0;
            for (int k = 1; k <= 6 && lat == 0; k++) begin
                step(1'b0, mk(0, 0), mk(0, 0), 1'b0, 1'b0, 1'b1, took, gave);
                if (gave) begin
                    lat = k;
                    if (sb.size() > 0) e = sb.pop_front();
                    n_cmp++;
                    if (o_r !== OW'(er[v]) || o_i !== OW'(ei[v])) begin
                        n_bad++;
                        $display("FAIL mul_value[%0d]: got (%0d,%0d) want (%0d,%0d)", v, o_r, o_i, er[v], ei[v]);
                    end
                end
            end
            n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL mul_latency[%0d]: got %0d want 3 (0 = none in 6)", v, lat); end
            step(1'b0, mk(0, 0), mk(0, 0), 1'b0, 1'b0, 1'b1, took, gave);
            n_cmp++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL mul_pulse[%0d]: o_vld %0b want 0", v, o_vld); end
        end
    endtask

    task automatic test_back_to_back();
        cplx_t a[16], b[16];
        bit    took, gave, en, stall_s;
        int    j = 0, first = -1, last_g = -1, ngave = 0, idx;
        res_t  e, held;
        for (int k = 0; k < 16; k++) begin a[k] = rnd(); b[k] = rnd(); end
        for (int s = 0; s < 20; s++) begin
            en = (j < 8);
            step(en, a[j], b[j], j[0], 1'b1, 1'b1, took, gave);
            if (en) begin
                n_cmp++; if (!took) begin n_bad++; $display("FAIL b2b_accept: sample %0d took %0b want 1", j, took); end
            end
            if (gave) begin
                if (first < 0) first = s;
                last_g = s; ngave++;
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL b2b_extra: (%0d,%0d) with empty scoreboard", o_r, o_i); end
                else begin
                    e = sb.pop_front();
                    if (o_r !== e.re || o_i !== e.im) begin n_bad++; $display("FAIL b2b_data: got (%0d,%0d) want (%0d,%0d)", o_r, o_i, e.re, e.im); end
                end
            end
            if (took) j++;
        end
        n_cmp++;
        if (ngave != 8 || last_g - first != 7) begin
            n_bad++; $display("FAIL b2b_gapless: %0d outputs over steps %0d..%0d want 8 consecutive", ngave, first, last_g);
        end
        for (int s = 0; s < 40 && (j < 16 || sb.size() > 0); s++) begin
            stall_s = (s >= 4 && s < 9);
            idx = (j < 16) ? j : 15;
            step(j < 16, a[idx], b[idx], idx[1], 1'b1, !stall_s, took, gave);
            if (s == 4) begin held.re = o_r; held.im = o_i; end
            if (stall_s) begin
                n_cmp++;
                if (o_vld !== 1'b1 || i_rdy !== 1'b0 || o_r !== held.re || o_i !== held.im) begin
                    n_bad++;
                    $display("FAIL stall_hold: vld %0b rdy %0b out (%0d,%0d) want vld 1 rdy 0 out (%0d,%0d)",
                             o_vld, i_rdy, o_r, o_i, held.re, held.im);
                end
            end
            if (gave) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL stall_extra: (%0d,%0d) with empty scoreboard", o_r, o_i); end
                else begin
                    e = sb.pop_front();
                    if (o_r !== e.re || o_i !== e.im) begin n_bad++; $display("FAIL stall_data: got (%0d,%0d) want (%0d,%0d)", o_r, o_i, e.re, e.im); end
                end
            end
            if (took) j++;
        end
        n_cmp++; if (j != 16 || sb.size() != 0) begin n_bad++; $display("FAIL stall_loss: sent %0d want 16, pending %0d want 0", j, sb.size()); end
    endtask

    task automatic test_async_reset();
        bit   took, gave;
        int   lat = 0;
        res_t e;
        for (int k = 0; k < 3; k++) step(1'b1, mk(3 + k, 4), mk(2, 1 + k), 1'b0, 1'b1, 1'b0, took, gave);
        step(1'b0, mk(0, 0), mk(0, 0), 1'b0, 1'b0, 1'b0, took, gave);
        n_cmp++; if (o_vld !== 1'b1 || o_r === '0) begin n_bad++; $display("FAIL areset_pre: vld %0b o_r %0d want vld 1 and nonzero", o_vld, o_r); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (o_vld !== 1'b0) begin n_bad++; $display("FAIL areset_vld: got %0b want 0", o_vld); end
        n_cmp++; if (o_r !== '0 || o_i !== '0) begin n_bad++; $display("FAIL areset_data: got (%0d,%0d) want (0,0)", o_r, o_i); end
        n_cmp++; if (i_rdy !== 1'b1) begin n_bad++; $display("FAIL areset_rdy: got %0b want 1", i_rdy); end
        sb.delete();
`ifdef COMP_MUL_ACC_EN
        mdl_acc_r = 0; mdl_acc_i = 0;
`endif
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        step(1'b1, mk(-7, 5), mk(6, -3), 1'b0, 1'b1, 1'b1, took, gave);
        for (int k = 1; k <= 6 && lat == 0; k++) begin
            step(1'b0, mk(0, 0), mk(0, 0), 1'b0, 1'b0, 1'b1, took, gave);
            if (gave) begin
                lat = k;
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL areset_extra: (%0d,%0d) with empty scoreboard", o_r, o_i); end
                else begin
                    e = sb.pop_front();
                    if (o_r !== e.re || o_i !== e.im || e.re !== OW'(-27) || e.im !== OW'(51)) begin
                        n_bad++; $display("FAIL areset_data2: got (%0d,%0d) want (-27,51)", o_r, o_i);
                    end
                end
            end
        end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL areset_latency: got %0d want 3", lat); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL areset_pending: %0d left want 0", sb.size()); end
    endtask

`ifdef COMP_MUL_ACC_EN
    task automatic test_acc();
        int  len[2] = '{4, 1};
        int  ar[2]  = '{1, 3};
        int  ai[2]  = '{1, 0};
        int  br[2]  = '{2, 3};
        int  er[2]  = '{8, 9};
        int  ei[2]  = '{8, 0};
        bit  took, gave;
        int  j, ngave;
        for (int r = 0; r < 2; r++) begin
            j = 0; ngave = 0;
            for (int s = 0; s < 12; s++) begin
                step(j < len[r], mk(ar[r], ai[r]), mk(br[r], 0), 1'b0, j == len[r] - 1, 1'b1, took, gave);
                if (gave) begin
                    ngave++;
                    if (sb.size() > 0) void'(sb.pop_front());
                    n_cmp++;
                    if (o_r !== OW'(er[r]) || o_i !== OW'(ei[r])) begin
                        n_bad++; $display("FAIL acc_value[%0d]: got (%0d,%0d) want (%0d,%0d)", r, o_r, o_i, er[r], ei[r]);
                    end
                end
                if (took) j++;
            end
            n_cmp++; if (ngave != 1) begin n_bad++; $display("FAIL acc_count[%0d]: got %0d outputs want 1", r, ngave); end
        end
    endtask
`endif

    task automatic test_random();
        localparam int N = 10000;
        cplx_t a, b;
        bit    cj, lst, en, rdy, took, gave;
        int    sent = 0;
        res_t  e;
        a = rnd(); b = rnd(); cj = 1'($urandom); lst = ($urandom_range(3) == 0);
        for (int s = 0; s < 60000 && sent < N; s++) begin
            en  = ($urandom_range(3) != 0);
            rdy = ($urandom_range(3) != 0);
            step(en, a, b, cj, lst, rdy, took, gave);
            if (gave) begin
                n_cmp++;
                if (sb.size() == 0) begin n_bad++; $display("FAIL rand_extra: (%0d,%0d) with empty scoreboard", o_r, o_i); end
                else begin
                    e = sb.pop_front();
                    if (o_r !== e.re || o_i !== e.im) begin n_bad++; $display("FAIL rand_data: got (%0d,%0d) want (%0d,%0d)", o_r, o_i, e.re, e.im); end
                end
            end
            if (took) begin
                sent++;
                a = rnd(); b = rnd(); cj = 1'($urandom);
                lst = ($urandom_range(3) == 0) || (sent == N - 1);
            end
        end
        n_cmp++; if (sent != N) begin n_bad++; $display("FAIL rand_timeout: sent %0d want %0d", sent, N); end
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            step(1'b0, a, b, 1'b0, 1'b0, 1'b1, took, gave);
            if (gave) begin
                n_cmp++;
                e = sb.pop_front();
                if (o_r !== e.re || o_i !== e.im) begin n_bad++; $display("FAIL rand_drain: got (%0d,%0d) want (%0d,%0d)", o_r, o_i, e.re, e.im); end
            end
        end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rand_pending: %0d results never produced", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_back_to_back();
        test_async_reset();
`ifdef COMP_MUL_ACC_EN
        test_acc();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
